fp16_mul_seq: RTL and testbench

- Multi-cycle IEEE-754 half-precision (FP16) multiplier controller.
- Sequences the biased-exponent add/subtract step, an 11-cycle shift-add mantissa multiply, normalisation and special-case handling behind a start/done handshake.
- Sits next to the FP16 exponent logic in the lab FP datapath and is the block that drives it, one operation at a time.

---
 rtl/fp16_mul_seq.sv | 140 ++++++++++++++
 tb/tb_fp16_mul_seq.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/fp16_mul_seq.sv
// Sequential FP16 multiplier: exponent add, 11-step shift-add mantissa multiply,
// normalise/special-case select, behind a start/done handshake.
module fp16_mul_seq #(
  parameter int BIAS = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic        ovf,
  output logic        unf
);

  typedef enum logic [2:0] {IDLE, EXP, MUL, NORM, DONE} state_t;

  state_t             state, state_nxt;
  logic [15:0]        a_q, b_q;
  logic               sign_q;
  logic signed [6:0]  e_q;
  logic [21:0]        mcand_q, acc_q;
  logic [10:0]        mplier_q;
  logic [3:0]         cnt_q;

  // Operand classification from the latched operands (denormals count as zero).
  logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  assign a_zero = (a_q[14:10] == 5'd0);
  assign b_zero = (b_q[14:10] == 5'd0);
  assign a_inf  = (&a_q[14:10]) && (a_q[9:0] == 10'd0);
  assign b_inf  = (&b_q[14:10]) && (b_q[9:0] == 10'd0);
  assign a_nan  = (&a_q[14:10]) && (a_q[9:0] != 10'd0);
  assign b_nan  = (&b_q[14:10]) && (b_q[9:0] != 10'd0);

  logic signed [6:0] e_norm;
  logic [9:0]        frac_norm;
  assign e_norm    = acc_q[21] ? e_q + 7'sd1 : e_q;
  assign frac_norm = acc_q[21] ? acc_q[20:11] : acc_q[19:10];

  logic [15:0] res_nxt;
  logic        ovf_nxt, unf_nxt;

  // NOTE: every signal assigned in a combinational block gets a default first,
  // otherwise any path that skips an assignment infers a latch.
  always_comb begin
    res_nxt = {sign_q, e_norm[4:0], frac_norm};
    ovf_nxt = 1'b0;
    unf_nxt = 1'b0;
    if (a_nan || b_nan || ((a_inf || b_inf) && (a_zero || b_zero))) begin
      res_nxt = 16'h7E00;
    end else if (a_inf || b_inf) begin
      res_nxt = {sign_q, 15'h7C00};
      ovf_nxt = 1'b1;
    end else if (a_zero || b_zero) begin
      res_nxt = {sign_q, 15'h0000};
    end else if (e_norm >= 7'sd31) begin
      res_nxt = {sign_q, 15'h7C00};
      ovf_nxt = 1'b1;
    end else if (e_norm <= 7'sd0) begin
      res_nxt = {sign_q, 15'h0000};
      unf_nxt = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = EXP;
      EXP:  state_nxt = MUL;
      // Eleven add/shift steps take the counter to 11; the cycle that sees 11 leaves.
      MUL:  if (cnt_q == 4'd11) state_nxt = NORM;
      NORM: state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == EXP) || (state == MUL) || (state == NORM);
    done = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q      <= 16'h0000;
      b_q      <= 16'h0000;
      sign_q   <= 1'b0;
      e_q      <= 7'sd0;
      mcand_q  <= 22'd0;
      mplier_q <= 11'd0;
      acc_q    <= 22'd0;
      cnt_q    <= 4'd0;
      result   <= 16'h0000;
      ovf      <= 1'b0;
      unf      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_q <= a;
            b_q <= b;
          end
        end
        EXP: begin
          sign_q   <= a_q[15] ^ b_q[15];
          e_q      <= 7'({2'b00, a_q[14:10]} + {2'b00, b_q[14:10]}) - 7'(BIAS);
          mcand_q  <= {11'd0, 1'b1, a_q[9:0]};
          mplier_q <= {1'b1, b_q[9:0]};
          acc_q    <= 22'd0;
          cnt_q    <= 4'd0;
        end
        MUL: begin
          if (cnt_q != 4'd11) begin
            if (mplier_q[0]) acc_q <= acc_q + mcand_q;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 4'd1;
          end
        end
        NORM: begin
          e_q    <= e_norm;
          result <= res_nxt;
          ovf    <= ovf_nxt;
          unf    <= unf_nxt;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp16_mul_seq.sv
// Self-checking bench for fp16_mul_seq: arithmetic reference model plus a
// per-cycle compare of busy/done/result/flags, driven by directed vectors.
module tb_fp16_mul_seq;

  logic        clk = 1'b0;
  logic        rst_n, start;
  logic [15:0] a, b;
  logic        busy, done, ovf, unf;
  logic [15:0] result;

  fp16_mul_seq #(.BIAS(15)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [17:0] got, input logic [17:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Reference: {result, ovf, unf} from plain integer arithmetic on the FP16 fields.
  function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y);
    int ex, ey, fx, fy, e, p, frac;
    logic s, zero, inf, nan;
    ex = int'(x[14:10]); ey = int'(y[14:10]);
    fx = int'(x[9:0]);   fy = int'(y[9:0]);
    s    = x[15] ^ y[15];
    zero = (ex == 0) || (ey == 0);
    inf  = (ex == 31 && fx == 0) || (ey == 31 && fy == 0);
    nan  = (ex == 31 && fx != 0) || (ey == 31 && fy != 0);
    p = (1024 + fx) * (1024 + fy);
    e = ex + ey - 15;
    if (p >= (1 << 21)) begin
      e++;
      frac = (p >> 11) & 1023;
    end else begin
      frac = (p >> 10) & 1023;
    end
    if (nan || (inf && zero)) return {16'h7E00, 2'b00};
    if (inf)                  return {s, 15'h7C00, 2'b10};
    if (zero)                 return {s, 15'h0000, 2'b00};
    if (e >= 31)              return {s, 15'h7C00, 2'b10};
    if (e <= 0)               return {s, 15'h0000, 2'b01};
    return {s, 5'(e), 10'(frac), 2'b00};
  endfunction

  // Transaction-level model: edge count, accept edge, held outputs.
  int          cyc = 0;
  int          k_acc = 0;
  bit          active = 1'b0;
  bit          rst_seen = 1'b0;
  logic [17:0] pend = '0;
  logic [17:0] held = '0;

  always @(posedge clk) begin
    int c;
    c = cyc + 1;
    if (!rst_n) begin
      rst_seen = 1'b1;
      active   = 1'b0;
      held     = '0;
    end else begin
      if (active && c == k_acc + 14) held = pend;
      if ((!active || cyc >= k_acc + 15) && start) begin
        active = 1'b1;
        k_acc  = c;
        pend   = model(a, b);
      end
    end
    cyc = c;
  end

  always @(negedge clk) begin
    if (rst_seen) begin
      check("busy", 18'(busy), 18'(active && cyc >= k_acc && cyc <= k_acc + 13));
      check("done", 18'(done), 18'(active && cyc == k_acc + 14));
      check("outputs", {result, ovf, unf}, held);
    end
  end

  task automatic wait_done(output bit got);
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (done) got = 1'b1;
      else @(negedge clk);
    end
    check("done_timeout", 18'(got), 18'd1);
  endtask

  task automatic run_op(input logic [15:0] x, input logic [15:0] y, input logic [17:0] lit);
    int k0;
    bit got;
    check("model_pin", model(x, y), lit);
    a = x; b = y; start = 1'b1;
    k0 = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    wait_done(got);
    check("latency", 18'(cyc - k0), 18'd14);
    check("result", {result, ovf, unf}, lit);
    @(negedge clk);
  endtask

  task automatic count_dones(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done) n++;
    end
  endtask

  initial begin
    int  n, d1;
    bit  got;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("rst_busy", 18'(busy), 18'd0);
    check("rst_done", 18'(done), 18'd0);
    check("rst_out", {result, ovf, unf}, 18'd0);

    run_op(16'h3C00, 16'h3C00, {16'h3C00, 2'b00});
    run_op(16'h3E00, 16'h3E00, {16'h4080, 2'b00});
    run_op(16'h4000, 16'hC200, {16'hC600, 2'b00});
    run_op(16'h7BFF, 16'h7BFF, {16'h7C00, 2'b10});
    run_op(16'h0400, 16'h0400, {16'h0000, 2'b01});
    run_op(16'h0000, 16'h3C00, {16'h0000, 2'b00});
    run_op(16'h7C00, 16'h0000, {16'h7E00, 2'b00});
    run_op(16'hFC00, 16'h3C00, {16'hFC00, 2'b10});
    run_op(16'h7C01, 16'h3C00, {16'h7E00, 2'b00});
    run_op(16'h5C00, 16'h5C00, {16'h7C00, 2'b10});
    run_op(16'h2000, 16'h1C00, {16'h0000, 2'b01});
    run_op(16'h2000, 16'h2000, {16'h0400, 2'b00});
    run_op(16'h8000, 16'h3C00, {16'h8000, 2'b00});

    // Start re-pulsed while busy and again during DONE: both ignored.
    a = 16'h4000; b = 16'h4200; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    a = 16'h3C00; b = 16'h3C00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(got);
    check("ctrl_result", {result, ovf, unf}, {16'h4600, 2'b00});
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    count_dones(20, n);
    check("ctrl_extra_done", 18'(n), 18'd0);

    // Start held high: back-to-back operations, done pulses 16 cycles apart.
    a = 16'h3E00; b = 16'h3E00; start = 1'b1;
    wait_done(got);
    d1 = cyc;
    check("b2b_first", {result, ovf, unf}, {16'h4080, 2'b00});
    @(negedge clk);
    wait_done(got);
    start = 1'b0;
    check("b2b_gap", 18'(cyc - d1), 18'd16);
    check("b2b_second", {result, ovf, unf}, {16'h4080, 2'b00});
    @(negedge clk);
    @(negedge clk);

    // Reset during MUL discards the operation.
    a = 16'h7BFF; b = 16'h7BFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_busy", 18'(busy), 18'd0);
    check("midrst_out", {result, ovf, unf}, 18'd0);
    count_dones(20, n);
    check("midrst_no_done", 18'(n), 18'd0);
    run_op(16'h4000, 16'hC200, {16'hC600, 2'b00});

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
